// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption controller. It runs one round per
// cycle and expands the key on the fly.
// Build option AES_SHARE_SBOX_EN: one 16-lane SubBytes block is time-shared
// between the key schedule and the cipher state. This adds a KEY cycle to each
// round, so a round takes two cycles. Without the macro, SubWord has its own
// 4 S-boxes and each round takes one cycle.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
//   in_*  : in_ready is high only in IDLE.
//   out_* : out_valid holds, and out_text stays stable, until out_ready is seen.
module aes_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy,
  output logic [3:0]   round
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
`ifdef AES_SHARE_SBOX_EN
    S_KEY   = 2'd3,
`endif
    S_DONE  = 2'd2
  } state_e;

`ifdef AES_SHARE_SBOX_EN
  localparam state_e S_PRE_ROUND = S_KEY;
`else
  localparam state_e S_PRE_ROUND = S_ROUND;
`endif

  // GF(2^8) doubling, reduction polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, aa, bb;
    acc = 8'h00;
    aa  = a;
    bb  = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) acc = acc ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return acc;
  endfunction

  // The S-box is computed as x^254 (the multiplicative inverse, with 0 mapping to 0)
  // followed by the affine transform. This replaces a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, inv;
    p   = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e         r_fsm;
  logic [127:0]   r_state, r_rkey, r_out_text;
  logic [3:0]     r_round;
  logic           r_out_valid, r_busy;

  // Packed byte views: index [15-i] holds byte i, so byte 0 sits in bits [127:120].
  logic [15:0][7:0] w_sb_in, w_sb_out, w_sr, w_mix;
  logic [127:0]     w_mc, w_next_state, w_next_rkey;
  logic [31:0]      w_rot, w_subword, w_temp;
  logic [31:0]      w_k0, w_k1, w_k2, w_k3;

  assign w_rot = {r_rkey[23:0], r_rkey[31:24]};

`ifdef AES_SHARE_SBOX_EN
  logic [31:0] r_subword;
  // In the KEY cycle, lanes 12..15 carry RotWord(w3). In all other cycles they carry the state.
  always_comb begin
    w_sb_in = r_state;
    if (r_fsm == S_KEY) w_sb_in[3:0] = w_rot;
  end
  assign w_subword = r_subword;
`else
  // SubBytes always carries the state; SubWord has its own lanes.
  always_comb begin
    w_sb_in = r_state;
  end
  for (genvar j = 0; j < 4; j++) begin : g_subword
    assign w_subword[8*j +: 8] = sbox(w_rot[8*j +: 8]);
  end
`endif

  for (genvar i = 0; i < 16; i++) begin : g_sbytes
    assign w_sb_out[i] = sbox(w_sb_in[i]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[15-(r+4*c)] = w_sb_out[15-(r+4*((c+r)%4))];
    end
    assign w_a0 = w_sr[15-4*c];
    assign w_a1 = w_sr[14-4*c];
    assign w_a2 = w_sr[13-4*c];
    assign w_a3 = w_sr[12-4*c];
    assign w_mix[15-4*c] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign w_mix[14-4*c] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign w_mix[13-4*c] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign w_mix[12-4*c] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

  // The final round skips MixColumns.
  assign w_mc = (r_round == 4'd10) ? w_sr : w_mix;

  assign w_temp       = w_subword ^ {rcon(r_round), 24'h000000};
  assign w_k0         = r_rkey[127:96] ^ w_temp;
  assign w_k1         = r_rkey[95:64]  ^ w_k0;
  assign w_k2         = r_rkey[63:32]  ^ w_k1;
  assign w_k3         = r_rkey[31:0]   ^ w_k2;
  assign w_next_rkey  = {w_k0, w_k1, w_k2, w_k3};
  assign w_next_state = w_mc ^ w_next_rkey;

  // Control FSM and every registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_round     <= 4'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_text  <= '0;
      r_state     <= '0;
      r_rkey      <= '0;
`ifdef AES_SHARE_SBOX_EN
      r_subword   <= '0;
`endif
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= in_text ^ in_key;
            r_rkey  <= in_key;
            r_round <= 4'd1;
            r_busy  <= 1'b1;
            r_fsm   <= S_PRE_ROUND;
          end
        end
`ifdef AES_SHARE_SBOX_EN
        S_KEY: begin
          r_subword <= w_sb_out[3:0];
          r_fsm     <= S_ROUND;
        end
`endif
        S_ROUND: begin
          r_state <= w_next_state;
          r_rkey  <= w_next_rkey;
          if (r_round == 4'd10) begin
            r_out_text  <= w_next_state;
            r_out_valid <= 1'b1;
            r_fsm       <= S_DONE;
          end else begin
            r_round <= r_round + 4'd1;
            r_fsm   <= S_PRE_ROUND;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_round     <= 4'd0;
            r_fsm       <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_fsm == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_text  = r_out_text;
  assign busy      = r_busy;
  assign round     = r_round;

endmodule
